key_scan: RTL

Debounced push-button front end for the Tang Nano board. It samples up to NUM_KEYS active-low raw button pins, synchronises and debounces each one, and converts them into a clean level plus single-cycle press, release, click (short press) and long-press events. Its consumer is the LED pattern logic, which uses these events to select blink modes.

---
 rtl/key_scan.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_scan.sv
// key_scan: debounced active-low push-button front end.
// Each key is synchronised, debounced and turned into a clean level plus
// single-cycle press / release / click (short press) / long-press events.
//
// Ports:
//   sys_clk      system clock, the only clock
//   sys_rst      synchronous active-high reset
//   key_n        raw button pins, active-low, asynchronous
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
//   key_click    one-cycle pulse with key_release if no long press fired
//   key_long     one-cycle pulse LONG_CYC cycles after key_press
module key_scan #(
  parameter int unsigned NUM_KEYS     = 2,
  parameter int unsigned DEBOUNCE_CYC = 270_000,
  parameter int unsigned LONG_CYC     = 27_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_click,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HW = $clog2(LONG_CYC + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          sync1, sync2, k;
    state_t        state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          long_flag, long_flag_nxt;
    logic          level_q, press_q, release_q, click_q, long_q;
    logic          level_nxt, press_nxt, release_nxt, click_nxt, long_nxt;

    assign k = ~sync2;

    // Synchroniser, state, counters and registered outputs
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        state     <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        long_flag <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        click_q   <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1     <= key_n[i];
        sync2     <= sync1;
        state     <= state_nxt;
        dcnt      <= dcnt_nxt;
        hcnt      <= hcnt_nxt;
        long_flag <= long_flag_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        click_q   <= click_nxt;
        long_q    <= long_nxt;
      end
    end

    // Next-state, counter and event logic
    always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      hcnt_nxt      = hcnt;
      long_flag_nxt = long_flag;
      level_nxt     = level_q;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      click_nxt     = 1'b0;
      long_nxt      = 1'b0;

      // Hold timer runs through release bounces; saturates at LONG_CYC
      if (state == HELD || state == DB_REL) begin
        if (hcnt < HOLD_MAX) hcnt_nxt = hcnt + HW'(1);
        if (hcnt == HOLD_LAST) begin
          long_nxt      = 1'b1;
          long_flag_nxt = 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (k) begin
            state_nxt = DB_PRESS;
            dcnt_nxt  = '0;
          end
        end
        DB_PRESS: begin
          if (!k) begin
            state_nxt = IDLE;
          end else if (dcnt == DB_LAST) begin
            state_nxt     = HELD;
            press_nxt     = 1'b1;
            level_nxt     = 1'b1;
            hcnt_nxt      = '0;
            long_flag_nxt = 1'b0;
          end else begin
            dcnt_nxt = dcnt + DW'(1);
          end
        end
        HELD: begin
          if (!k) begin
            state_nxt = DB_REL;
            dcnt_nxt  = '0;
          end
        end
        DB_REL: begin
          if (k) begin
            state_nxt = HELD;
          end else if (dcnt == DB_LAST) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            // A long event firing on this same edge also suppresses the click
            click_nxt   = ~(long_flag | long_nxt);
            level_nxt   = 1'b0;
          end else begin
            dcnt_nxt = dcnt + DW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_click[i]   = click_q;
    assign key_long[i]    = long_q;
  end

endmodule
